// File: rtl/rtl_kernel_wizard_1_axis_byteswap.sv
// AXI4-Stream byte-swap stage: reverses byte order within each C_SWAP_BYTES lane, with the mode latched per packet.
// Registered s_axis_tready backed by an output register and a one-entry skid buffer; keeps beat/packet statistics.
module rtl_kernel_wizard_1_axis_byteswap #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_SWAP_BYTES       = 4,
    parameter int C_COUNT_WIDTH      = 32
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            ctrl_swap_en,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [C_COUNT_WIDTH-1:0]        stat_beat_count,
    output logic [C_COUNT_WIDTH-1:0]        stat_pkt_count,
    output logic                            stat_busy
);
    localparam int KEEP_W = C_AXIS_TDATA_WIDTH / 8;
    localparam logic [C_COUNT_WIDTH-1:0] CNT_ONE = C_COUNT_WIDTH'(1);

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

    function automatic int src_byte(input int i);
        return (i / C_SWAP_BYTES) * C_SWAP_BYTES + (C_SWAP_BYTES - 1 - (i % C_SWAP_BYTES));
    endfunction

    function automatic logic [C_AXIS_TDATA_WIDTH-1:0] swap_data(input logic [C_AXIS_TDATA_WIDTH-1:0] d);
        logic [C_AXIS_TDATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < KEEP_W; i++)
            r[i*8 +: 8] = d[src_byte(i)*8 +: 8];
        return r;
    endfunction

    function automatic logic [KEEP_W-1:0] swap_keep(input logic [KEEP_W-1:0] k);
        logic [KEEP_W-1:0] r;
        r = '0;
        for (int i = 0; i < KEEP_W; i++)
            r[i] = k[src_byte(i)];
        return r;
    endfunction

    function automatic logic [C_COUNT_WIDTH-1:0] sat_inc(input logic [C_COUNT_WIDTH-1:0] c,
                                                        input logic en);
        if (en && (c != '1))
            return c + CNT_ONE;
        return c;
    endfunction

    state_t state_q, state_d;
    logic   pkt_mode_q, pkt_mode_d;
    logic   rdy_q;
    logic   accept, emit, beat_swap;

    logic [C_AXIS_TDATA_WIDTH-1:0] swp_data_p0;
    logic [KEEP_W-1:0]             swp_keep_p0;

    logic                          vld_p1, vld_p1_d;
    logic [C_AXIS_TDATA_WIDTH-1:0] data_p1;
    logic [KEEP_W-1:0]             keep_p1;
    logic                          last_p1;

    logic                          skid_vld_p1, skid_vld_p1_d;
    logic [C_AXIS_TDATA_WIDTH-1:0] skid_data_p1;
    logic [KEEP_W-1:0]             skid_keep_p1;
    logic                          skid_last_p1;

    logic load_out_in, load_out_skid, load_skid;
    logic [C_COUNT_WIDTH-1:0] beat_cnt_q, pkt_cnt_q;

    assign accept = s_axis_tvalid & rdy_q;
    assign emit   = vld_p1 & m_axis_tready;

    // Stage p0: choose the mode for this beat and permute data/keep at acceptance
    assign beat_swap   = (state_q == IDLE) ? ctrl_swap_en : pkt_mode_q;
    assign swp_data_p0 = beat_swap ? swap_data(s_axis_tdata) : s_axis_tdata;
    assign swp_keep_p0 = beat_swap ? swap_keep(s_axis_tkeep) : s_axis_tkeep;

    always_comb begin
        state_d    = state_q;
        pkt_mode_d = pkt_mode_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    pkt_mode_d = ctrl_swap_en;
                    if (!s_axis_tlast)
                        state_d = IN_PKT;
                end
                IN_PKT: begin
                    if (s_axis_tlast)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage p1: OUT register plus skid; accept is impossible while SKID is full
    always_comb begin
        vld_p1_d      = vld_p1;
        skid_vld_p1_d = skid_vld_p1;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (emit) begin
            if (skid_vld_p1) begin
                load_out_skid = 1'b1;
                skid_vld_p1_d = 1'b0;
            end else if (accept) begin
                load_out_in = 1'b1;
            end else begin
                vld_p1_d = 1'b0;
            end
        end else if (accept) begin
            if (!vld_p1) begin
                load_out_in = 1'b1;
                vld_p1_d    = 1'b1;
            end else begin
                load_skid     = 1'b1;
                skid_vld_p1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            pkt_mode_q  <= 1'b0;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_q       <= 1'b0;
            beat_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pkt_mode_q  <= pkt_mode_d;
            vld_p1      <= vld_p1_d;
            skid_vld_p1 <= skid_vld_p1_d;
            rdy_q       <= ~skid_vld_p1_d;
            beat_cnt_q  <= sat_inc(beat_cnt_q, emit);
            pkt_cnt_q   <= sat_inc(pkt_cnt_q, emit & last_p1);
        end
    end

    always_ff @(posedge aclk) begin
        if (load_out_skid) begin
            data_p1 <= skid_data_p1;
            keep_p1 <= skid_keep_p1;
            last_p1 <= skid_last_p1;
        end else if (load_out_in) begin
            data_p1 <= swp_data_p0;
            keep_p1 <= swp_keep_p0;
            last_p1 <= s_axis_tlast;
        end
        if (load_skid) begin
            skid_data_p1 <= swp_data_p0;
            skid_keep_p1 <= swp_keep_p0;
            skid_last_p1 <= s_axis_tlast;
        end
    end

    assign s_axis_tready   = rdy_q;
    assign m_axis_tvalid   = vld_p1;
    assign m_axis_tdata    = data_p1;
    assign m_axis_tkeep    = keep_p1;
    assign m_axis_tlast    = last_p1;
    assign stat_beat_count = beat_cnt_q;
    assign stat_pkt_count  = pkt_cnt_q;
    assign stat_busy       = (state_q == IN_PKT);

endmodule

// File: tb/tb_rtl_kernel_wizard_1_axis_byteswap.sv
// Scoreboard bench: three 32-bit instances (lane sizes 4, 2, 1) share one input stream and are checked
// against a byte-reversal reference model; the lane-1 instance uses 4-bit counters to exercise saturation.
module tb_rtl_kernel_wizard_1_axis_byteswap;
    localparam int W  = 32;
    localparam int KW = W / 8;
    localparam int CW = 32;
    localparam int SW = 4;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic ctrl_swap_en = 1'b0;
    logic s_valid = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic [KW-1:0] s_keep = '0;
    logic s_last = 1'b0;
    logic m_ready = 1'b0;
    logic rand_ready = 1'b0;

    logic          s_ready [3];
    logic          m_valid [3];
    logic [W-1:0]  m_data  [3];
    logic [KW-1:0] m_keep  [3];
    logic          m_last  [3];
    logic          busy    [3];
    logic [CW-1:0] beats   [2];
    logic [CW-1:0] pkts    [2];
    logic [SW-1:0] beats_sm, pkts_sm;

    always #5 aclk = ~aclk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rtl_kernel_wizard_1_axis_byteswap #(
            .C_AXIS_TDATA_WIDTH(W), .C_SWAP_BYTES(g == 0 ? 4 : 2), .C_COUNT_WIDTH(CW)
        ) u_dut (
            .aclk(aclk), .areset(areset), .ctrl_swap_en(ctrl_swap_en),
            .s_axis_tvalid(s_valid), .s_axis_tready(s_ready[g]), .s_axis_tdata(s_data),
            .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
            .m_axis_tvalid(m_valid[g]), .m_axis_tready(m_ready), .m_axis_tdata(m_data[g]),
            .m_axis_tkeep(m_keep[g]), .m_axis_tlast(m_last[g]),
            .stat_beat_count(beats[g]), .stat_pkt_count(pkts[g]), .stat_busy(busy[g])
        );
    end

    rtl_kernel_wizard_1_axis_byteswap #(
        .C_AXIS_TDATA_WIDTH(W), .C_SWAP_BYTES(1), .C_COUNT_WIDTH(SW)
    ) u_dut_s1 (
        .aclk(aclk), .areset(areset), .ctrl_swap_en(ctrl_swap_en),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready[2]), .s_axis_tdata(s_data),
        .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
        .m_axis_tvalid(m_valid[2]), .m_axis_tready(m_ready), .m_axis_tdata(m_data[2]),
        .m_axis_tkeep(m_keep[2]), .m_axis_tlast(m_last[2]),
        .stat_beat_count(beats_sm), .stat_pkt_count(pkts_sm), .stat_busy(busy[2])
    );

    typedef struct packed {
        logic [W-1:0]  d4, d2, d1;
        logic [KW-1:0] k4, k2, k1;
        logic          last;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_beats = 0;
    int   exp_pkts = 0;
    logic m_in_pkt = 1'b0;
    logic m_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: reverse every s-byte group of the beat, treating it as a list of bytes.
    function automatic logic [W-1:0] ref_swap_data(input logic [W-1:0] d, input int s);
        logic [7:0] b [KW];
        logic [7:0] t;
        logic [W-1:0] r;
        for (int i = 0; i < KW; i++) b[i] = d[8*i +: 8];
        for (int base = 0; base < KW; base += s)
            for (int j = 0; j < s / 2; j++) begin
                t = b[base+j]; b[base+j] = b[base+s-1-j]; b[base+s-1-j] = t;
            end
        for (int i = 0; i < KW; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    function automatic logic [KW-1:0] ref_swap_keep(input logic [KW-1:0] k, input int s);
        logic [KW-1:0] r;
        logic t;
        r = k;
        for (int base = 0; base < KW; base += s)
            for (int j = 0; j < s / 2; j++) begin
                t = r[base+j]; r[base+j] = r[base+s-1-j]; r[base+s-1-j] = t;
            end
        return r;
    endfunction

    task automatic send(input logic [W-1:0] d, input logic [KW-1:0] k, input logic last,
                        input logic en, output int waited);
        exp_t e;
        logic mode;
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = last; ctrl_swap_en = en;
        waited = 0;
        forever begin
            @(negedge aclk);
            if (s_ready[0]) break;
            waited++;
            if (waited > 200) break;
        end
        if (waited > 200) begin
            check("accept_timeout", 64'(waited), 64'(0));
            s_valid = 1'b0;
            return;
        end
        mode = m_in_pkt ? m_mode : en;
        if (!m_in_pkt) m_mode = en;
        m_in_pkt = !last;
        e.d4 = mode ? ref_swap_data(d, 4) : d;
        e.d2 = mode ? ref_swap_data(d, 2) : d;
        e.d1 = mode ? ref_swap_data(d, 1) : d;
        e.k4 = mode ? ref_swap_keep(k, 4) : k;
        e.k2 = mode ? ref_swap_keep(k, 2) : k;
        e.k1 = mode ? ref_swap_keep(k, 1) : k;
        e.last = last;
        sbq.push_back(e);
        @(posedge aclk); #1;
        check("stat_busy", 64'(busy[0]), 64'(m_in_pkt));
    endtask

    task automatic idle();
        s_valid = 1'b0;
        @(posedge aclk); #1;
    endtask

    // Random downstream readiness while enabled
    initial forever begin
        @(posedge aclk); #1;
        if (rand_ready) m_ready = ($urandom_range(0, 99) < 70);
    end

    // Monitor: pops the scoreboard on every output handshake and watches AXIS stability
    initial begin
        logic hold;
        logic [W+KW:0] held;
        exp_t e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                hold = 1'b0;
            end else begin
                check("beat_count", 64'(beats[0]), 64'(exp_beats));
                check("pkt_count", 64'(pkts[0]), 64'(exp_pkts));
                check("beat_count_sat", 64'(beats_sm), 64'(exp_beats > 15 ? 15 : exp_beats));
                check("pkt_count_sat", 64'(pkts_sm), 64'(exp_pkts > 15 ? 15 : exp_pkts));
                if (hold) begin
                    check("hold_valid", 64'(m_valid[0]), 64'(1));
                    check("hold_stable", 64'({m_data[0], m_keep[0], m_last[0]}), 64'(held));
                end
                if (m_valid[0] && m_ready) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_beat", 64'(0), 64'(1));
                    end else begin
                        e = sbq.pop_front();
                        check("out_s4", 64'({m_valid[0], m_data[0], m_keep[0], m_last[0]}),
                              64'({1'b1, e.d4, e.k4, e.last}));
                        check("out_s2", 64'({m_valid[1], m_data[1], m_keep[1], m_last[1]}),
                              64'({1'b1, e.d2, e.k2, e.last}));
                        check("out_s1", 64'({m_valid[2], m_data[2], m_keep[2], m_last[2]}),
                              64'({1'b1, e.d1, e.k1, e.last}));
                    end
                    exp_beats++;
                    if (m_last[0]) exp_pkts++;
                    hold = 1'b0;
                end else if (m_valid[0]) begin
                    hold = 1'b1;
                    held = {m_data[0], m_keep[0], m_last[0]};
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, tw, len;
        logic [CW-1:0] b0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_m_valid", 64'(m_valid[0]), 64'(0));
        check("rst_s_ready", 64'(s_ready[0]), 64'(0));
        check("rst_beats", 64'(beats[0]), 64'(0));
        check("rst_pkts", 64'(pkts[0]), 64'(0));
        check("rst_busy", 64'(busy[0]), 64'(0));
        areset = 1'b0;
        @(posedge aclk); #1;
        check("ready_after_rst", 64'(s_ready[0]), 64'(1));

        // Single-beat packet, swap on, all three lane sizes
        m_ready = 1'b1;
        send(32'h11223344, 4'b0011, 1'b1, 1'b1, w);
        check("latency_valid", 64'(m_valid[0]), 64'(1));
        check("s4_data", 64'(m_data[0]), 64'(32'h44332211));
        check("s4_keep", 64'(m_keep[0]), 64'(4'b1100));
        check("s4_last", 64'(m_last[0]), 64'(1));
        check("s2_data", 64'(m_data[1]), 64'(32'h22114433));
        check("s2_keep", 64'(m_keep[1]), 64'(4'b0011));
        check("s1_data", 64'(m_data[2]), 64'(32'h11223344));
        idle();
        check("single_beats", 64'(beats[0]), 64'(1));
        check("single_pkts", 64'(pkts[0]), 64'(1));

        // Continuous 16-beat stream at full throughput
        b0 = beats[0];
        tw = 0;
        for (int i = 0; i < 16; i++) begin
            send($urandom, 4'hF, i == 15, 1'b1, w);
            tw += w;
        end
        check("stream_stalls", 64'(tw), 64'(0));
        idle();
        check("stream_beats", 64'(beats[0] - b0), 64'(16));

        // Backpressure: OUT=1, SKID=2, then 3 waits for release
        m_ready = 1'b0;
        send(32'h1, 4'hF, 1'b0, 1'b0, w);
        send(32'h2, 4'hF, 1'b0, 1'b0, w);
        check("skid_ready_drop", 64'(s_ready[0]), 64'(0));
        check("bp_out_data", 64'(m_data[0]), 64'(32'h1));
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1;
            check("bp_ready_low", 64'(s_ready[0]), 64'(0));
        end
        m_ready = 1'b1;
        send(32'h3, 4'hF, 1'b1, 1'b0, w);
        check("bp_release_wait", 64'(w), 64'(1));
        idle();
        idle();

        // Mode latched at packet start; toggling mid-packet is ignored
        send(32'h01234567, 4'hF, 1'b0, 1'b1, w);
        check("busy_after_b0", 64'(busy[0]), 64'(1));
        send(32'h89ABCDEF, 4'hF, 1'b0, 1'b1, w);
        send(32'hAABBCCDD, 4'hF, 1'b0, 1'b0, w);
        check("mid_toggle_swapped", 64'(m_data[0]), 64'(32'hDDCCBBAA));
        send(32'h55667788, 4'hF, 1'b1, 1'b0, w);
        check("busy_after_b3", 64'(busy[0]), 64'(0));
        send(32'h01020304, 4'hF, 1'b1, 1'b0, w);
        check("next_pkt_pass", 64'(m_data[0]), 64'(32'h01020304));
        idle();
        idle();

        // Reset mid-packet with OUT and SKID full
        m_ready = 1'b0;
        send(32'hCAFEF00D, 4'hF, 1'b0, 1'b1, w);
        send(32'hDEADBEEF, 4'hF, 1'b0, 1'b1, w);
        s_valid = 1'b0;
        areset = 1'b1;
        sbq.delete();
        m_in_pkt = 1'b0; m_mode = 1'b0; exp_beats = 0; exp_pkts = 0;
        @(posedge aclk); #1;
        check("midrst_m_valid", 64'(m_valid[0]), 64'(0));
        check("midrst_s_ready", 64'(s_ready[0]), 64'(0));
        check("midrst_beats", 64'(beats[0]), 64'(0));
        check("midrst_pkts", 64'(pkts[0]), 64'(0));
        check("midrst_busy", 64'(busy[0]), 64'(0));
        areset = 1'b0;
        @(posedge aclk); #1;
        check("midrst_ready_after", 64'(s_ready[0]), 64'(1));
        m_ready = 1'b1;
        send(32'h11223344, 4'hF, 1'b1, 1'b0, w);
        check("post_rst_pass", 64'(m_data[0]), 64'(32'h11223344));
        idle();
        idle();

        // Randomized packets, random gaps, random downstream readiness
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                send($urandom, 4'($urandom_range(0, 15)), b == len - 1, 1'($urandom_range(0, 1)), w);
                if ($urandom_range(0, 3) == 0) idle();
            end
        end
        s_valid = 1'b0;
        rand_ready = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge aclk);
        @(posedge aclk); #1;
        check("drain_empty", 64'(sbq.size()), 64'(0));
        check("final_busy", 64'(busy[0]), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtl_kernel_wizard_1_axis_byteswap.md
Name: rtl_kernel_wizard_1_axis_byteswap

Overview:
AXI4-Stream byte-swap stage placed directly downstream of the pipelined adder FIFO output. It reverses byte order inside each C_SWAP_BYTES-wide lane of every beat, for example to convert endianness before the write master. The swap mode is latched per packet. The stage provides full throughput with a registered s_axis_tready, using an output register plus a skid register, and keeps beat and packet statistics.

Parameters:
C_AXIS_TDATA_WIDTH, 512, data width of both streams; must be a multiple of 8.
C_SWAP_BYTES, 4, lane size in bytes for reversal; power of 2, must divide C_AXIS_TDATA_WIDTH/8; 1 means identity.
C_COUNT_WIDTH, 32, width of the statistics counters.

Ports:
aclk  in  1  single clock for all logic.
areset  in  1  synchronous reset, active-high.
ctrl_swap_en  in  1  1 = swap, 0 = pass-through; sampled on the first beat of each packet.
s_axis_tvalid  in  1  input beat valid.
s_axis_tready  out  1  input ready; driven directly from a flop.
s_axis_tdata  in  C_AXIS_TDATA_WIDTH  input data.
s_axis_tkeep  in  C_AXIS_TDATA_WIDTH/8  input byte enables.
s_axis_tlast  in  1  end of packet.
m_axis_tvalid  out  1  output beat valid.
m_axis_tready  in  1  downstream ready.
m_axis_tdata  out  C_AXIS_TDATA_WIDTH  swapped data.
m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  tkeep permuted identically to the data bytes.
m_axis_tlast  out  1  tlast passed through.
stat_beat_count  out  C_COUNT_WIDTH  number of output handshakes.
stat_pkt_count  out  C_COUNT_WIDTH  number of output handshakes with tlast=1.
stat_busy  out  1  1 while an input packet is partially accepted.

Behaviour:
- Accept condition: s_axis_tvalid & s_axis_tready. Emit condition: m_axis_tvalid & m_axis_tready.
- Swap mapping, with S = C_SWAP_BYTES and lane k: output byte k*S+j = input byte k*S+(S-1-j). The tkeep bit mapping is identical. When the mode is 0, data and tkeep pass unchanged. tlast is never altered.
- Mode FSM, two states:
  - IDLE: an accepted beat uses the live ctrl_swap_en and latches it into pkt_mode.
    - Beat with tlast=0: go to IN_PKT.
    - Beat with tlast=1: stay in IDLE (single-beat packet).
  - IN_PKT: accepted beats use pkt_mode; ctrl_swap_en changes are ignored. An accepted beat with tlast=1 returns to IDLE.
  - stat_busy = (state == IN_PKT).
- Swap is applied at input acceptance; the swapped beat is written into the output register or the skid register.
- Output register (OUT) drives m_axis_*. Skid register (SKID) captures one beat when OUT is held.
  - s_axis_tready is registered: next value = ~(SKID valid next cycle).
  - Latency: a beat accepted in cycle N with OUT empty, or OUT being emitted in N, appears on m_axis_tvalid in cycle N+1.
  - Throughput: 1 beat/cycle while m_axis_tready=1.
- Backpressure:
  - m_axis_tready=0 with OUT full: the next accepted beat goes to SKID, and s_axis_tready drops in the following cycle.
  - On the next emit, SKID moves to OUT and s_axis_tready rises one cycle later.
  - No beat is lost, duplicated or reordered.
- Accept and emit in the same cycle:
  - SKID empty: the new beat loads OUT directly.
  - SKID full: SKID moves to OUT; no accept is possible, because s_axis_tready=0.
- AXIS rules: once m_axis_tvalid=1, it and tdata/tkeep/tlast stay stable until the emit. m_axis_tvalid does not depend combinationally on m_axis_tready.
- Counters: stat_beat_count increments by 1 per emit, and stat_pkt_count per emit with tlast=1. Both saturate at all-ones and do not wrap.
- Reset, while areset=1:
  - m_axis_tvalid=0, s_axis_tready=0, OUT and SKID invalid.
  - FSM in IDLE, pkt_mode=0, counters=0.
  - s_axis_tready=1 in the first cycle after areset deasserts.
  - tdata, tkeep and tlast are not reset; they are don't-care while tvalid=0.
- Reset mid-packet: all buffered beats are discarded, and the FSM returns to IDLE. The next accepted beat is treated as a packet start.

Test Plan:
- Width 32, S=4, swap_en=1, single beat: tdata=0x11223344, tkeep=4'b0011, tlast=1 → m_axis at N+1 carries 0x44332211, tkeep 4'b1100, tlast=1; pkt_count=1, beat_count=1.
- Width 32, S=2, swap_en=1: 0x11223344 → 0x22114433. S=1 → 0x11223344 unchanged.
- Continuous 16 beats with m_axis_tready=1 → 16 consecutive output beats, s_axis_tready stays 1, beat_count=16.
- m_axis_tready=0 for 5 cycles during a stream of 0x1,0x2,0x3 → OUT=0x1, SKID=0x2, s_axis_tready=0 from the cycle after SKID fills. On release, outputs are 0x1,0x2,0x3 in order with no gaps or duplicates.
- A 4-beat packet with swap_en=1 on beat 0 and toggled to 0 on beat 2 → all 4 beats swapped, stat_busy=1 from after beat 0 until after beat 3. The next packet with swap_en=0 passes through unswapped.
- areset asserted after beat 2 of a 4-beat packet while OUT and SKID are full → m_axis_tvalid=0 and counters=0 during reset. The next beat, with swap_en=0 and tlast=1, is treated as a new packet and passes through unswapped.
